// File: rtl/cache_pkg.sv
// Types and block geometry shared by the cache fill controller and the cache
// data/tag arrays.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_OFF_W      = 3;

endpackage

// File: rtl/fill_word_ctr.sv
// Word-offset counter for a cache block fill: wraps modulo the block size, with
// clear, enable and a start-offset load.
module fill_word_ctr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] start,
  output logic [WIDTH-1:0] count
);

  // Power-of-two block size, so natural binary wrap gives the modulo behaviour.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= start;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from main memory and strobes it
// into the data and tag arrays. Critical-word-first ordering: CACHE_FILL_CRIT_WORD_FIRST_EN.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic [15:0]                        memory_data,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [15:0]                        fill_data,
  output logic                               write_tag_array,
  output logic                               crit_word_vld
);

  localparam int WOFF = $clog2(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((2 * WORDS_PER_BLOCK) - 1);

  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 || (1 << WOFF) != WORDS_PER_BLOCK) begin : g_bad_cfg
    $error("cache_fill_fsm: MEM_LATENCY must be >= 1 and WORDS_PER_BLOCK a power of 2 >= 2");
  end

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [WOFF-1:0]   crit;
  logic [WOFF-1:0]   crit_last;
  logic [WOFF-1:0]   start_word;
  logic [WOFF-1:0]   issue_cnt;
  logic [WOFF-1:0]   issue_next;
  logic [WOFF-1:0]   recv_cnt;
  logic              issuing;
  logic              start;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  assign start_word    = miss_address[WOFF:1];
  assign crit_word_vld = write_data_array & (recv_cnt == crit);
`else
  assign start_word    = '0;
  assign crit_word_vld = 1'b0;
`endif

  assign start            = (state == IDLE) & miss_detected;
  assign fsm_busy         = (state == FILL) | start;
  assign mem_rd_en        = (state == FILL) & issuing;
  assign memory_address   = base | ADDR_W'({issue_cnt, 1'b0});
  assign issue_next       = issue_cnt + 1'b1;
  assign crit_last        = crit - 1'b1;
  assign write_data_array = (state == FILL) & memory_data_valid;
  assign write_tag_array  = write_data_array & (recv_cnt == crit_last);
  assign fill_word        = recv_cnt;
  assign fill_data        = memory_data;

  fill_word_ctr #(.WIDTH(WOFF)) u_issue_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .load  (start),
    .en    (mem_rd_en),
    .start (start_word),
    .count (issue_cnt)
  );

  fill_word_ctr #(.WIDTH(WOFF)) u_recv_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .load  (start),
    .en    (write_data_array),
    .start (start_word),
    .count (recv_cnt)
  );

  // Issuing stops once the word just before the start word has been requested;
  // the fill ends with the tag write that accompanies the final returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      crit    <= '0;
      issuing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state   <= FILL;
            base    <= miss_address & ~OFF_MASK;
            crit    <= start_word;
            issuing <= 1'b1;
          end
        end
        FILL: begin
          if (mem_rd_en && (issue_next == crit)) begin
            issuing <= 1'b0;
          end
          if (write_tag_array) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a 4-cycle memory model feeds a write scoreboard, and
// expected request addresses are queued at each miss and popped as requests appear.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic        crit_word_vld;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .ADDR_W          (16),
    .WORDS_PER_BLOCK (8),
    .MEM_LATENCY     (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_rd_en         (mem_rd_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .crit_word_vld     (crit_word_vld)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  typedef struct {
    logic [2:0]  word;
    logic [15:0] data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  ret_t        mem_q[$];
  logic [15:0] req_q[$];
  wr_t         wr_q[$];

  logic        obs_busy, obs_rd, obs_wr, obs_tag, obs_crit;
  logic [15:0] obs_addr, obs_data;
  logic [2:0]  obs_word;

  function automatic logic [2:0] first_word(input logic [15:0] addr);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    return addr[3:1];
`else
    return 3'd0;
`endif
  endfunction

  function automatic void push_requests(input logic [15:0] addr);
    logic [15:0] base;
    int          w;
    base = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      w = (int'(first_word(addr)) + i) % 8;
      req_q.push_back(base + 16'(2 * w));
    end
  endfunction

  // One clock cycle: drive inputs, run the memory model, sample at the falling
  // edge and settle the request/write scoreboards.
  task automatic tick(input logic miss, input logic [15:0] addr, input logic spur, input logic rst_in);
    ret_t        r;
    wr_t         w;
    logic [15:0] exp_addr;
    rst               = rst_in;
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = 1'b0;
    memory_data       = 16'($urandom);
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      r = mem_q.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = r.data;
    end else if (spur) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hDEAD;
    end
    @(negedge clk);
    obs_busy = fsm_busy;
    obs_rd   = mem_rd_en;
    obs_addr = memory_address;
    obs_wr   = write_data_array;
    obs_word = fill_word;
    obs_data = fill_data;
    obs_tag  = write_tag_array;
    obs_crit = crit_word_vld;
    if (obs_rd) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL extra_request cyc=%0d got addr=%h required no request", cyc, obs_addr);
      end else begin
        exp_addr = req_q.pop_front();
        if (obs_addr !== exp_addr) begin
          errors++;
          $display("[TB] FAIL request_addr cyc=%0d got=%h required=%h", cyc, obs_addr, exp_addr);
        end
      end
      r.due  = cyc + 4;
      r.data = 16'hA000 + {13'd0, obs_addr[3:1]};
      mem_q.push_back(r);
      w.word = obs_addr[3:1];
      w.data = r.data;
      wr_q.push_back(w);
    end
    if (obs_wr) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL extra_write cyc=%0d got word=%0d data=%h required no write", cyc, obs_word, obs_data);
      end else begin
        w = wr_q.pop_front();
        if (obs_word !== w.word || obs_data !== w.data) begin
          errors++;
          $display("[TB] FAIL write_word cyc=%0d got word=%0d data=%h required word=%0d data=%h",
                   cyc, obs_word, obs_data, w.word, w.data);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_in) begin
      mem_q.delete();
      req_q.delete();
      wr_q.delete();
    end
  endtask

  // A full fill from the miss cycle (c=0) through the tag-write cycle (c=12).
  task automatic run_fill(input logic [15:0] addr, input logic mid_miss, output int busy_cycles);
    logic exp_rd, exp_wr, exp_tag, exp_crit;
    busy_cycles = 0;
    push_requests(addr);
    for (int c = 0; c < 13; c++) begin
      if (c == 0) tick(1'b1, addr, 1'b0, 1'b0);
      else if (mid_miss && c == 3) tick(1'b1, 16'h4000, 1'b0, 1'b0);
      else tick(1'b0, 16'h0000, 1'b0, 1'b0);
      exp_rd  = (c >= 1 && c <= 8);
      exp_wr  = (c >= 5 && c <= 12);
      exp_tag = (c == 12);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
      exp_crit = (c == 5);
`else
      exp_crit = 1'b0;
`endif
      busy_cycles += int'(obs_busy);
      checks += 5;
      if (obs_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fill_busy addr=%h c=%0d got=%b required=1", addr, c, obs_busy);
      end
      if (obs_rd !== exp_rd) begin
        errors++;
        $display("[TB] FAIL fill_rd_en addr=%h c=%0d got=%b required=%b", addr, c, obs_rd, exp_rd);
      end
      if (obs_wr !== exp_wr) begin
        errors++;
        $display("[TB] FAIL fill_wr addr=%h c=%0d got=%b required=%b", addr, c, obs_wr, exp_wr);
      end
      if (obs_tag !== exp_tag) begin
        errors++;
        $display("[TB] FAIL fill_tag addr=%h c=%0d got=%b required=%b", addr, c, obs_tag, exp_tag);
      end
      if (obs_crit !== exp_crit) begin
        errors++;
        $display("[TB] FAIL crit_vld addr=%h c=%0d got=%b required=%b", addr, c, obs_crit, exp_crit);
      end
    end
    checks++;
    if (req_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL fill_complete addr=%h got pending req=%0d wr=%0d required 0/0",
               addr, req_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset;
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if ({obs_busy, obs_rd, obs_wr, obs_tag, obs_crit, obs_addr, obs_word} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b rd=%b wr=%b tag=%b crit=%b addr=%h word=%0d required all 0",
               obs_busy, obs_rd, obs_wr, obs_tag, obs_crit, obs_addr, obs_word);
    end
  endtask

  task automatic test_idle_after(input string name);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (obs_busy !== 1'b0 || obs_rd !== 1'b0 || obs_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle got busy=%b rd=%b wr=%b required 0/0/0", name, obs_busy, obs_rd, obs_wr);
    end
  endtask

  task automatic test_linear_fill;
    int b;
    run_fill(16'h1236, 1'b0, b);
    checks++;
    if (b != 13) begin
      errors++;
      $display("[TB] FAIL linear_busy_cycles got=%0d required=13", b);
    end
    test_idle_after("linear");
  endtask

  task automatic test_miss_mid_fill;
    int b;
    run_fill(16'h1236, 1'b1, b);
    test_idle_after("mid_miss");
  endtask

  task automatic test_spurious_valid;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
      checks++;
      if (obs_wr !== 1'b0 || obs_tag !== 1'b0 || obs_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL spurious_valid i=%0d got wr=%b tag=%b busy=%b required 0/0/0",
                 i, obs_wr, obs_tag, obs_busy);
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    int b;
    push_requests(16'h1236);
    for (int c = 0; c <= 6; c++) begin
      tick(c == 0, 16'h1236, 1'b0, c == 6);
    end
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if ({obs_busy, obs_rd, obs_wr, obs_tag, obs_crit, obs_addr, obs_word} !== '0) begin
      errors++;
      $display("[TB] FAIL midfill_reset_outputs got busy=%b rd=%b wr=%b tag=%b crit=%b addr=%h word=%0d required all 0",
               obs_busy, obs_rd, obs_wr, obs_tag, obs_crit, obs_addr, obs_word);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0000, 1'b0, 1'b0);
      checks++;
      if (obs_tag !== 1'b0 || obs_wr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midfill_no_tag i=%0d got tag=%b wr=%b required 0/0", i, obs_tag, obs_wr);
      end
    end
    run_fill(16'h2000, 1'b0, b);
    test_idle_after("after_reset");
  endtask

  task automatic test_back_to_back;
    int b1, b2;
    run_fill(16'h3008, 1'b0, b1);
    run_fill(16'h555E, 1'b0, b2);
    checks++;
    if (b1 + b2 != 26) begin
      errors++;
      $display("[TB] FAIL back_to_back_busy got=%0d required=26", b1 + b2);
    end
    test_idle_after("back_to_back");
  endtask

  task automatic test_crit_word;
    int b;
    run_fill(16'h123C, 1'b0, b);
    test_idle_after("crit");
  endtask

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data       = 16'h0000;
    memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_linear_fill;
    test_miss_mid_fill;
    test_spurious_valid;
    test_reset_mid_fill;
    test_back_to_back;
    test_crit_word;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
